booth_mult_seq: RTL
===================

Name: booth_mult_seq

Overview:
Parametrised sequential radix-2 Booth multiplier. It is the next-generation replacement for the fixed 32-bit multiplier feeding HI/LO in the MIPS datapath. Improvements over the previous generation:
- operand width is a parameter;
- supports signed and unsigned operation (MULT/MULTU);
- explicit Busy/Done handshake;
- deterministic latency;
- results hold stably between operations.

Parameters:
WIDTH, 32, operand width in bits (legal range 4..64). Hi and Lo are each WIDTH bits.

Ports:
Clock  in  1  rising-edge clock
Reset  in  1  synchronous, active-high reset
Start  in  1  request; sampled only when the FSM is in IDLE or DONE
Signed  in  1  1 = two's-complement operands (MULT), 0 = unsigned (MULTU); sampled with Start
A  in  WIDTH  multiplicand; sampled with Start
B  in  WIDTH  multiplier; sampled with Start
Busy  out  1  high while in RUN
Done  out  1  one-cycle pulse when Hi/Lo are updated
Hi  out  WIDTH  upper half of the 2*WIDTH-bit product
Lo  out  WIDTH  lower half of the 2*WIDTH-bit product

Behaviour:
- Reset: synchronous, active-high, Reset; clock Clock.
  - On reset: state = IDLE, Busy = 0, Done = 0, Hi = 0, Lo = 0, all internal registers cleared.
  - Reset has priority over every other input, including mid-RUN; the operation in flight is discarded and Done is not pulsed.
- Operand extension: operands are extended to E = WIDTH+1 bits.
  - Signed = 1: sign-extend.
  - Signed = 0: zero-extend.
  - One Booth datapath therefore serves both modes.
- Registers:
  - M (E bits) holds the extended A.
  - P (2E+1 bits) holds {E zeros, extended B, 1'b0}.
  - cnt counts iterations.
- States: IDLE, RUN, DONE.
  - IDLE: Start=1 → load M, P, cnt=E; go to RUN. Start=0 → stay.
  - RUN: Busy=1. Each cycle:
    - if P[1:0] = 01, P.upper += M; if 10, P.upper -= M (modulo 2^E); 00/11 no add;
    - then arithmetic-shift P right by 1 (the MSB is replicated);
    - cnt -= 1.
    - On the cycle where cnt reaches 0, go to DONE and register Hi = P[2W:W+1] and Lo = P[W:1] of the final value (i.e. the low 2*WIDTH product bits).
  - DONE: Done=1 for exactly this cycle; Busy=0. Start=1 loads a new operation (back-to-back, same as IDLE); otherwise go to IDLE.
- Latency: Start sampled at edge 0; Done is high in the cycle following edge WIDTH+1. Total WIDTH+2 cycles including the request cycle. Latency is independent of operand values and of mode.
- Start while Busy=1 is ignored; the running operation is unaffected. A, B and Signed may change freely after being sampled.
- Hi/Lo hold their last result until the next DONE; they never show intermediate values.
- Overflow is impossible: the 2*WIDTH-bit product is exact in both modes.
- Edge cases that need no special handling: A = most-negative value (−2^(W−1)) with Signed=1 is correct because of the E-bit extension; a zero operand takes full latency.

Decomposition:
- Package booth_mult_pkg:
  - state enum {IDLE, RUN, DONE};
  - localparam function for counter width: $clog2(WIDTH+2).
- Sub-module booth_step (combinational, parameter E): input P, M; output the next P (conditional add/sub plus arithmetic shift right). It is instantiated once, and can be unit-tested exhaustively at E=5.

Test Plan:
- WIDTH=32, Signed=1, A=0xFFFFFFFF, B=0xFFFFFFFF → Done at cycle 34 after Start, Hi=0x00000000, Lo=0x00000001; Busy high for exactly 33 cycles.
- WIDTH=32, Signed=0, A=B=0xFFFFFFFF → Hi=0xFFFFFFFE, Lo=0x00000001.
- WIDTH=32, Signed=1:
  - A=B=0x80000000 → Hi=0x40000000, Lo=0x00000000;
  - A=7, B=0xFFFFFFFD → Hi=0xFFFFFFFF, Lo=0xFFFFFFEB.
- Sequencing, WIDTH=32:
  - Start A=3, B=5; pulse Start with A=9, B=9 at cycle 10 → first result Hi=0, Lo=15, the second Start is ignored.
  - Start asserted in the DONE cycle → second result follows back-to-back with the same latency.
- Reset at cycle 20 of RUN → Busy=0, Hi=Lo=0 next cycle, no Done pulse; a fresh Start afterwards completes correctly.
- WIDTH=8:
  - Signed=0, 0xFF*0xFF → Hi=0xFE, Lo=0x01 after 10 cycles;
  - random sweep of 10k operand/mode pairs against a reference model.

Source files
------------

// File: rtl/booth_mult_pkg.sv
// booth_mult_pkg
//   Shared types and helpers for the sequential Booth multiplier.
//   state_t   : controller states (IDLE, RUN, DONE)
//   cnt_width : iteration-counter width for a given operand width
package booth_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The counter is loaded with WIDTH+1, so it must represent values up to WIDTH+1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/booth_step.sv
// booth_step
//   One radix-2 Booth iteration on the partial-product register.
//   p_in  [2E:0] : {upper E bits, multiplier E bits, appended Booth bit}
//   m     [E-1:0]: extended multiplicand
//   p_out [2E:0] : p_in after conditional add/sub of m into the upper field,
//                  then an arithmetic shift right by one
module booth_step #(
  parameter int E = 5
) (
  input  logic [2*E:0] p_in,
  input  logic [E-1:0] m,
  output logic [2*E:0] p_out
);

  logic [E-1:0] upper;
  logic [2*E:0] sum_p;

  always_comb begin
    upper = p_in[2*E:E+1];
    case (p_in[1:0])
      2'b01:   upper = upper + m;
      2'b10:   upper = upper - m;
      default: upper = p_in[2*E:E+1];
    endcase
    sum_p = {upper, p_in[E:0]};
    // Arithmetic shift: the MSB is replicated into the vacated position.
    p_out = {sum_p[2*E], sum_p[2*E:1]};
  end

endmodule

// File: rtl/booth_mult_seq.sv
// booth_mult_seq
//   Sequential radix-2 Booth multiplier, signed (MULT) or unsigned (MULTU).
//   Operands are extended to WIDTH+1 bits so one datapath serves both modes.
//   Clock, Reset   : rising-edge clock, synchronous active-high reset
//   Start          : request, accepted in IDLE or DONE only
//   Signed, A, B   : mode and operands, sampled with Start
//   Busy           : high while iterating
//   Done           : one-cycle pulse when Hi/Lo are updated
//   Hi, Lo         : upper/lower halves of the 2*WIDTH-bit product, held
//
//   state | meaning
//   IDLE  | waiting for Start
//   RUN   | one Booth iteration per cycle, WIDTH+1 iterations
//   DONE  | result registered, Done pulsed; Start here chains a new operation
module booth_mult_seq
  import booth_mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int E  = WIDTH + 1;
  localparam int CW = cnt_width(WIDTH);

  state_t         state;
  logic [E-1:0]   m_reg;
  logic [2*E:0]   p_reg;
  logic [2*E:0]   p_next;
  logic [CW-1:0]  cnt;

  booth_step #(.E(E)) u_step (
    .p_in  (p_reg),
    .m     (m_reg),
    .p_out (p_next)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      m_reg <= '0;
      p_reg <= '0;
      cnt   <= '0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
      Hi    <= '0;
      Lo    <= '0;
    end else begin
      case (state)
        RUN: begin
          p_reg <= p_next;
          cnt   <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state <= DONE;
            Busy  <= 1'b0;
            Done  <= 1'b1;
            // Low 2*WIDTH bits of the product sit just above the Booth bit.
            Hi    <= p_next[2*WIDTH:WIDTH+1];
            Lo    <= p_next[WIDTH:1];
          end
        end
        default: begin
          Done <= 1'b0;
          if (Start) begin
            state <= RUN;
            Busy  <= 1'b1;
            m_reg <= {Signed & A[WIDTH-1], A};
            p_reg <= {{E{1'b0}}, Signed & B[WIDTH-1], B, 1'b0};
            cnt   <= CW'(E);
          end else begin
            state <= IDLE;
            Busy  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
